// File: rtl/sdram_pkg.sv
// Shared SDRAM geometry constants and the request arbiter state encoding.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_LINE_W = 128;
    localparam int BANK_W       = 2;
    localparam int ROW_W        = 13;
    localparam int COL_W        = 10;

    // One-hot, matching the controller's state style.
    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StIssue = 3'b010,
        StDone  = 3'b100
    } arb_state_e;

    function automatic logic [SDRAM_ADDR_W-1:0] make_line_addr(
        input logic [BANK_W-1:0] bank,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col
    );
        return {bank, row, col};
    endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational two-way round-robin pick: the requester that was not served last wins a tie.
module sdram_rr_picker (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last;
            default: o_winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/sdram_request_arbiter.sv
// Two-client round-robin front end onto the SDRAM controller's single request port,
// with one transaction open at a time and a watchdog on the controller ack.
module sdram_request_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int DATA_W  = SDRAM_LINE_W,
    parameter int TIMEOUT = 4095
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ic0_req,
    input  logic              ic0_we,
    input  logic [ADDR_W-1:0] ic0_address,
    input  logic [DATA_W-1:0] ic0_wdata,
    output logic              oc0_ack,
    output logic [DATA_W-1:0] oc0_rdata,
    input  logic              ic1_req,
    input  logic              ic1_we,
    input  logic [ADDR_W-1:0] ic1_address,
    input  logic [DATA_W-1:0] ic1_wdata,
    output logic              oc1_ack,
    output logic [DATA_W-1:0] oc1_rdata,
    output logic              owrite_req,
    output logic [ADDR_W-1:0] owrite_address,
    output logic [DATA_W-1:0] owrite_data,
    input  logic              iwrite_ack,
    output logic              oread_req,
    output logic [ADDR_W-1:0] oread_address,
    input  logic [DATA_W-1:0] iread_data,
    input  logic              iread_ack,
    output logic              ogrant,
    output logic              obusy,
    output logic              oerror
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    // Last ISSUE cycle index before the watchdog fires; the request is held TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        r_state;
    logic              r_we;
    logic              r_last;
    logic [CNT_W-1:0]  r_wd_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write_req;
    logic              r_read_req;
    logic              r_c0_ack;
    logic              r_c1_ack;
    logic [DATA_W-1:0] r_c0_rdata;
    logic [DATA_W-1:0] r_c1_rdata;
    logic              r_grant;
    logic              r_busy;
    logic              r_error;

    logic              w_valid;
    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_ack_match;

    sdram_rr_picker u_picker (
        .i_req    ({ic1_req, ic0_req}),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_sel_we    = w_winner ? ic1_we      : ic0_we;
    assign w_sel_addr  = w_winner ? ic1_address : ic0_address;
    assign w_sel_wdata = w_winner ? ic1_wdata   : ic0_wdata;

    // An ack of the opposite direction is not ours and is ignored.
    assign w_ack_match = r_we ? iwrite_ack : iread_ack;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_last      <= 1'b1;
            r_wd_cnt    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write_req <= 1'b0;
            r_read_req  <= 1'b0;
            r_c0_ack    <= 1'b0;
            r_c1_ack    <= 1'b0;
            r_c0_rdata  <= '0;
            r_c1_rdata  <= '0;
            r_grant     <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_c0_ack <= 1'b0;
            r_c1_ack <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        r_grant     <= w_winner;
                        r_we        <= w_sel_we;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_write_req <= w_sel_we;
                        r_read_req  <= ~w_sel_we;
                        r_wd_cnt    <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_ack_match || (r_wd_cnt == CNT_LAST)) begin
                        // Drop the request on the ack edge so the controller never re-issues it.
                        r_write_req <= 1'b0;
                        r_read_req  <= 1'b0;
                        r_c0_ack    <= ~r_grant;
                        r_c1_ack    <= r_grant;
                        r_last      <= r_grant;
                        r_state     <= StDone;
                        if (w_ack_match) begin
                            if (!r_we && !r_grant) begin
                                r_c0_rdata <= iread_data;
                            end
                            if (!r_we && r_grant) begin
                                r_c1_rdata <= iread_data;
                            end
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign oc0_ack        = r_c0_ack;
    assign oc1_ack        = r_c1_ack;
    assign oc0_rdata      = r_c0_rdata;
    assign oc1_rdata      = r_c1_rdata;
    assign owrite_req     = r_write_req;
    assign owrite_address = r_addr;
    assign owrite_data    = r_wdata;
    assign oread_req      = r_read_req;
    assign oread_address  = r_addr;
    assign ogrant         = r_grant;
    assign obusy          = r_busy;
    assign oerror         = r_error;

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Bench for sdram_request_arbiter: two client models, a controller model and a per-client scoreboard.
module tb_sdram_request_arbiter;

    localparam int AW = 25;
    localparam int DW = 128;
    localparam int TO = 15;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } stim_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            len;
        logic          err;
    } exp_t;

    logic          iclk = 1'b0;
    logic          ireset;
    logic [1:0]    c_req;
    logic [1:0]    c_we;
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_wdata [2];
    logic          oc0_ack, oc1_ack;
    logic [DW-1:0] oc0_rdata, oc1_rdata;
    logic          owrite_req, oread_req;
    logic [AW-1:0] owrite_address, oread_address;
    logic [DW-1:0] owrite_data, iread_data;
    logic          iwrite_ack, iread_ack;
    logic          ogrant, obusy, oerror;

    always #5 iclk = ~iclk;

    sdram_request_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .iclk           (iclk),
        .ireset         (ireset),
        .ic0_req        (c_req[0]),
        .ic0_we         (c_we[0]),
        .ic0_address    (c_addr[0]),
        .ic0_wdata      (c_wdata[0]),
        .oc0_ack        (oc0_ack),
        .oc0_rdata      (oc0_rdata),
        .ic1_req        (c_req[1]),
        .ic1_we         (c_we[1]),
        .ic1_address    (c_addr[1]),
        .ic1_wdata      (c_wdata[1]),
        .oc1_ack        (oc1_ack),
        .oc1_rdata      (oc1_rdata),
        .owrite_req     (owrite_req),
        .owrite_address (owrite_address),
        .owrite_data    (owrite_data),
        .iwrite_ack     (iwrite_ack),
        .oread_req      (oread_req),
        .oread_address  (oread_address),
        .iread_data     (iread_data),
        .iread_ack      (iread_ack),
        .ogrant         (ogrant),
        .obusy          (obusy),
        .oerror         (oerror)
    );

    stim_t         stim_q [2][$];
    exp_t          sb_q [2][$];
    int            acked_order [$];
    logic [DW-1:0] m_rdata [2];
    logic          m_err;
    int            ctl_delay, ctl_wrong_at;
    logic          ctl_never;
    int            hi_cnt, last_hi;
    logic          rise_we, unstable;
    logic [AW-1:0] rise_addr;
    logic [DW-1:0] rise_data;
    int            n_cmp, n_err;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ctl_data(input logic [AW-1:0] addr);
        return {32'hDEAD_BEEF, 32'h0000_0001, 39'd0, addr};
    endfunction

    // Controller model first, then both client models; runs once per falling edge.
    task automatic service();
        logic          hi;
        logic          ack;
        logic [DW-1:0] rdata;
        logic [AW-1:0] cur_addr;
        exp_t          e;
        stim_t         s;
        iwrite_ack = 1'b0;
        iread_ack  = 1'b0;
        iread_data = {4{32'hBAD0_BAD0}};
        hi         = owrite_req | oread_req;
        cur_addr   = owrite_req ? owrite_address : oread_address;
        if (hi) begin
            check_eq("req_exclusive", DW'(owrite_req & oread_req), '0);
            if (hi_cnt == 0) begin
                rise_we   = owrite_req;
                rise_addr = cur_addr;
                rise_data = owrite_data;
                unstable  = 1'b0;
            end else if (owrite_req != rise_we || cur_addr != rise_addr ||
                         owrite_data != rise_data) begin
                unstable = 1'b1;
            end
            hi_cnt++;
            if (!ctl_never && hi_cnt == ctl_delay) begin
                if (owrite_req) begin
                    iwrite_ack = 1'b1;
                end else begin
                    iread_ack  = 1'b1;
                    iread_data = ctl_data(oread_address);
                end
            end
            if (ctl_wrong_at != 0 && hi_cnt == ctl_wrong_at) begin
                if (owrite_req) iread_ack = 1'b1;
                else iwrite_ack = 1'b1;
            end
        end else if (hi_cnt != 0) begin
            last_hi = hi_cnt;
            hi_cnt  = 0;
        end

        for (int c = 0; c < 2; c++) begin
            ack   = (c == 1) ? oc1_ack : oc0_ack;
            rdata = (c == 1) ? oc1_rdata : oc0_rdata;
            if (ack) begin
                acked_order.push_back(c);
                if (sb_q[c].size() == 0) begin
                    check_eq($sformatf("c%0d_spurious_ack", c), DW'(1), '0);
                end else begin
                    e = sb_q[c].pop_front();
                    check_eq($sformatf("c%0d_rdata", c), rdata, e.rdata);
                    check_eq($sformatf("c%0d_dir", c), DW'(rise_we), DW'(e.we));
                    check_eq($sformatf("c%0d_addr", c), DW'(rise_addr), DW'(e.addr));
                    if (e.we) check_eq($sformatf("c%0d_wdata", c), rise_data, e.wdata);
                    check_eq($sformatf("c%0d_req_cycles", c), DW'(last_hi), DW'(e.len));
                    check_eq($sformatf("c%0d_stable", c), DW'(unstable), '0);
                    check_eq($sformatf("c%0d_oerror", c), DW'(oerror), DW'(e.err));
                end
                c_req[c] = 1'b0;
            end else if (!c_req[c] && stim_q[c].size() != 0) begin
                s          = stim_q[c].pop_front();
                c_req[c]   = 1'b1;
                c_we[c]    = s.we;
                c_addr[c]  = s.addr;
                c_wdata[c] = s.wdata;
                e.we       = s.we;
                e.addr     = s.addr;
                e.wdata    = s.wdata;
                if (ctl_never) begin
                    e.len = TO;
                    m_err = 1'b1;
                end else begin
                    e.len = ctl_delay;
                    if (!s.we) m_rdata[c] = ctl_data(s.addr);
                end
                e.err   = m_err;
                e.rdata = m_rdata[c];
                sb_q[c].push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge iclk);
        service();
    endtask

    function automatic int pending();
        return stim_q[0].size() + stim_q[1].size() + sb_q[0].size() + sb_q[1].size() +
               int'(c_req[0]) + int'(c_req[1]) + int'(obusy);
    endfunction

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (pending() != 0 && n < budget);
        check_eq({tag, "_drained"}, DW'(pending()), '0);
    endtask

    initial begin
        int n_before;
        int w;
        n_cmp        = 0;
        n_err        = 0;
        ireset       = 1'b1;
        c_req        = '0;
        c_we         = '0;
        c_addr[0]    = '0;
        c_addr[1]    = '0;
        c_wdata[0]   = '0;
        c_wdata[1]   = '0;
        iwrite_ack   = 1'b0;
        iread_ack    = 1'b0;
        iread_data   = '0;
        m_rdata[0]   = '0;
        m_rdata[1]   = '0;
        m_err        = 1'b0;
        ctl_delay    = 10;
        ctl_wrong_at = 0;
        ctl_never    = 1'b0;
        hi_cnt       = 0;
        last_hi      = 0;
        rise_we      = 1'b0;
        unstable     = 1'b0;
        rise_addr    = '0;
        rise_data    = '0;

        repeat (3) @(negedge iclk);
        check_eq("rst_write_req", DW'(owrite_req), '0);
        check_eq("rst_read_req", DW'(oread_req), '0);
        check_eq("rst_busy", DW'(obusy), '0);
        check_eq("rst_error", DW'(oerror), '0);
        check_eq("rst_grant", DW'(ogrant), '0);
        check_eq("rst_acks", DW'({oc1_ack, oc0_ack}), '0);
        check_eq("rst_c0_rdata", oc0_rdata, '0);
        check_eq("rst_c1_rdata", oc1_rdata, '0);
        check_eq("rst_addr", DW'(owrite_address), '0);
        check_eq("rst_wdata", owrite_data, '0);
        ireset = 1'b0;

        // Single write, controller acks after 10 request cycles.
        stim_q[0].push_back('{1'b1, 25'h0123456, {16{8'hA5}}});
        run_idle("t1", 200);

        // Single read on client 1; returned data must hold afterward.
        stim_q[1].push_back('{1'b0, 25'h1FFFFFF, '0});
        run_idle("t2", 200);
        repeat (4) tick();
        check_eq("t2_c1_rdata_hold", oc1_rdata, {32'hDEAD_BEEF, 32'h0000_0001, 39'd0, 25'h1FFFFFF});
        check_eq("t2_c0_rdata_hold", oc0_rdata, '0);

        // Both clients continuously requesting: strict alternation starting at client 0.
        acked_order.delete();
        ctl_delay = 3;
        for (int i = 0; i < 3; i++) begin
            stim_q[0].push_back('{1'b1, AW'(32'h0000_100 + i), {4{32'h1111_0000 + 32'(i)}}});
            stim_q[1].push_back('{1'b0, AW'(32'h0ABC_000 + i), '0});
        end
        run_idle("t3", 500);
        check_eq("t3_ack_count", DW'(acked_order.size()), DW'(6));
        for (int i = 0; i < 6; i++) begin
            w = (i < acked_order.size()) ? acked_order[i] : 2;
            check_eq($sformatf("t3_grant%0d", i), DW'(w), DW'(i % 2));
        end

        // Controller never acks: watchdog fires, error is sticky, next request still served.
        ctl_never = 1'b1;
        stim_q[0].push_back('{1'b0, 25'h0155555, '0});
        run_idle("t4a", 200);
        ctl_never = 1'b0;
        ctl_delay = 5;
        stim_q[1].push_back('{1'b1, 25'h0000042, {8{16'hC0DE}}});
        run_idle("t4b", 200);
        check_eq("t4_error_sticky", DW'(oerror), DW'(1));

        // Wrong-direction ack mid read must be ignored.
        ctl_delay    = 8;
        ctl_wrong_at = 3;
        stim_q[0].push_back('{1'b0, 25'h0AAAAAA, '0});
        run_idle("t5", 200);
        ctl_wrong_at = 0;

        // Asynchronous reset in the middle of a client 1 write.
        ctl_never = 1'b1;
        stim_q[1].push_back('{1'b1, 25'h0777777, {4{32'h5A5A_5A5A}}});
        w = 0;
        while (hi_cnt < 4 && w < 50) begin
            tick();
            w++;
        end
        check_eq("t6_reached_issue", DW'(hi_cnt >= 4), DW'(1));
        #2 ireset = 1'b1;
        #1;
        check_eq("t6_async_req_drop", DW'(owrite_req), '0);
        check_eq("t6_busy_cleared", DW'(obusy), '0);
        check_eq("t6_error_cleared", DW'(oerror), '0);
        sb_q[1].delete();
        stim_q[1].delete();
        c_req[1]   = 1'b0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_err      = 1'b0;
        hi_cnt     = 0;
        ctl_never  = 1'b0;
        ctl_delay  = 4;
        n_before   = acked_order.size();
        repeat (3) tick();
        check_eq("t6_no_abort_ack", DW'(acked_order.size()), DW'(n_before));
        ireset = 1'b0;
        acked_order.delete();
        stim_q[1].push_back('{1'b0, 25'h0000001, '0});
        stim_q[0].push_back('{1'b0, 25'h0000002, '0});
        run_idle("t6", 200);
        w = (acked_order.size() > 0) ? acked_order[0] : 2;
        check_eq("t6_first_grant", DW'(w), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
